// File: rtl/sram_bank_rd_arbiter.sv
// Per-bank SRAM read-port arbiter: round-robin ownership of the bank held for a
// whole burst, with a fixed-latency return pipeline that tags each beat with its owner.
module sram_bank_rd_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BANK_ID      = 0,
    parameter int BANK_CNT_LG2 = 2,
    parameter int DEPTH_LG2    = 10,
    parameter int DATA_WIDTH   = 256,
    parameter int RD_LAT       = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_i,
    input  logic [NUM_REQ*BANK_CNT_LG2-1:0]   rid_i,
    input  logic [NUM_REQ*DEPTH_LG2-1:0]      addr_i,
    input  logic [NUM_REQ-1:0]                reb_i,
    input  logic [NUM_REQ-1:0]                rlast_i,
    output logic [NUM_REQ-1:0]                ack_o,
    output logic [DATA_WIDTH-1:0]             rdata_o,
    output logic [NUM_REQ-1:0]                rvalid_o,
    output logic                              sram_reb_o,
    output logic [DEPTH_LG2-1:0]              sram_addr_o,
    input  logic [DATA_WIDTH-1:0]             sram_rdata_i,
    output logic                              busy_o
);

    localparam int OW = $clog2(NUM_REQ);
    localparam logic [BANK_CNT_LG2-1:0] BANK_SEL = BANK_CNT_LG2'(BANK_ID);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t               state_q, state_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [OW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [RD_LAT-1:0]    pipe_vld;
    logic [OW-1:0]        pipe_own [RD_LAT];

    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   owner_mask;
    logic                 sel_reb;
    logic                 sel_rlast;
    logic                 sel_elig;
    logic [DEPTH_LG2-1:0] sel_addr;
    logic                 beat;
    logic                 release_now;
    logic [OW:0]          pick;

    function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] idx);
        if (int'(idx) >= NUM_REQ - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // Returns {found, index} of the first set bit searching start, start+1, ... modulo NUM_REQ.
    function automatic logic [OW:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                            input logic [OW-1:0]      start);
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rot;
        logic [OW:0]          res;
        int                   pos;
        dbl = {elig, elig} >> start;
        rot = dbl[NUM_REQ-1:0];
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            pos = int'(start) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (rot[i]) begin
                res = {1'b1, OW'(pos)};
            end
        end
        return res;
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            eligible[k] = req_i[k] && (rid_i[k*BANK_CNT_LG2 +: BANK_CNT_LG2] == BANK_SEL);
        end
    end

    always_comb begin
        sel_reb   = 1'b1;
        sel_rlast = 1'b0;
        sel_elig  = 1'b0;
        sel_addr  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_q == OW'(k)) begin
                sel_reb   = reb_i[k];
                sel_rlast = rlast_i[k];
                sel_elig  = eligible[k];
                sel_addr  = addr_i[k*DEPTH_LG2 +: DEPTH_LG2];
            end
        end
    end

    assign owner_mask  = NUM_REQ'(1) << owner_q;
    assign beat        = (state_q == BUSY) && !sel_reb;
    // An eligibility drop on the rlast beat still issues that beat; both paths release.
    assign release_now = (state_q == BUSY) && ((beat && sel_rlast) || !sel_elig);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        pick     = '0;
        case (state_q)
            IDLE: begin
                pick = rr_pick(eligible, rr_ptr_q);
                if (pick[OW]) begin
                    owner_d = pick[OW-1:0];
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (release_now) begin
                    rr_ptr_d = wrap_inc(owner_q);
                    pick     = rr_pick(eligible & ~owner_mask, wrap_inc(owner_q));
                    if (pick[OW]) begin
                        owner_d = pick[OW-1:0];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Beats carry their issuing owner so returns stay correct across a handoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                pipe_own[s] <= '0;
            end
        end else begin
            pipe_vld[0] <= beat;
            pipe_own[0] <= owner_q;
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_own[s] <= pipe_own[s-1];
            end
        end
    end

    assign busy_o      = (state_q == BUSY);
    assign ack_o       = busy_o ? owner_mask : '0;
    assign sram_reb_o  = busy_o ? sel_reb : 1'b1;
    assign sram_addr_o = busy_o ? sel_addr : '0;
    assign rvalid_o    = pipe_vld[RD_LAT-1] ? (NUM_REQ'(1) << pipe_own[RD_LAT-1]) : '0;
    assign rdata_o     = sram_rdata_i;

endmodule

// File: tb/tb_sram_bank_rd_arbiter.sv
// Directed bench for sram_bank_rd_arbiter: one instance with RD_LAT=2 and one with
// RD_LAT=3 share all inputs; each scenario checks the instance it targets.
module tb_sram_bank_rd_arbiter;

    localparam int NR = 4;
    localparam int BL = 2;
    localparam int DL = 10;
    localparam int DW = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*BL-1:0]  rid;
    logic [NR*DL-1:0]  addr;
    logic [NR-1:0]     reb;
    logic [NR-1:0]     rlast;
    logic [DW-1:0]     sram_rdata;

    logic [NR-1:0]     ack2, rvalid2, ack3, rvalid3;
    logic [DW-1:0]     rdata2, rdata3;
    logic              sram_reb2, sram_reb3, busy2, busy3;
    logic [DL-1:0]     sram_addr2, sram_addr3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_bank_rd_arbiter #(
        .NUM_REQ(NR), .BANK_ID(0), .BANK_CNT_LG2(BL),
        .DEPTH_LG2(DL), .DATA_WIDTH(DW), .RD_LAT(2)
    ) dut2 (
        .clk(clk), .rst(rst), .req_i(req), .rid_i(rid), .addr_i(addr),
        .reb_i(reb), .rlast_i(rlast), .ack_o(ack2), .rdata_o(rdata2),
        .rvalid_o(rvalid2), .sram_reb_o(sram_reb2), .sram_addr_o(sram_addr2),
        .sram_rdata_i(sram_rdata), .busy_o(busy2)
    );

    sram_bank_rd_arbiter #(
        .NUM_REQ(NR), .BANK_ID(0), .BANK_CNT_LG2(BL),
        .DEPTH_LG2(DL), .DATA_WIDTH(DW), .RD_LAT(3)
    ) dut3 (
        .clk(clk), .rst(rst), .req_i(req), .rid_i(rid), .addr_i(addr),
        .reb_i(reb), .rlast_i(rlast), .ack_o(ack3), .rdata_o(rdata3),
        .rvalid_o(rvalid3), .sram_reb_o(sram_reb3), .sram_addr_o(sram_addr3),
        .sram_rdata_i(sram_rdata), .busy_o(busy3)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NR-1:0] r, input logic [NR-1:0] rb,
                                 input logic [NR-1:0] rl);
        req   = r;
        reb   = rb;
        rlast = rl;
    endtask

    task automatic set_addr(input int k, input int a);
        addr[k*DL +: DL] = DL'(a);
    endtask

    task automatic set_rid(input int k, input int v);
        rid[k*BL +: BL] = BL'(v);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    // Leaves the bench one time unit after an edge with rst low: that cycle is cycle 0.
    task automatic do_reset();
        rst = 1'b1;
        applyStimulus('0, '1, '0);
        rid  = '0;
        addr = '0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        sram_rdata = {4{64'hA5A5_0123_4567_89AB}};

        // Single requester, 4-beat burst, RD_LAT=2
        do_reset();
        applyStimulus(4'b0010, 4'b1111, 4'b0000);
        settle();
        checkOutput("reset_ack", ack2, 4'b0000);
        checkOutput("reset_busy", busy2, 1'b0);
        checkOutput("reset_sram_reb", sram_reb2, 1'b1);
        checkOutput("reset_sram_addr", sram_addr2, 0);
        checkOutput("reset_rvalid", rvalid2, 4'b0000);
        next_cycle();
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(4'b0010, 4'b1101, (c == 4) ? 4'b0010 : 4'b0000);
            set_addr(1, 4 + c);
            settle();
            checkOutput("single_ack", ack2, 4'b0010);
            checkOutput("single_busy", busy2, 1'b1);
            checkOutput("single_sram_addr", sram_addr2, 4 + c);
            checkOutput("single_sram_reb", sram_reb2, 1'b0);
            checkOutput("single_rvalid", rvalid2, (c >= 3) ? 4'b0010 : 4'b0000);
            next_cycle();
        end
        for (int c = 5; c <= 7; c++) begin
            applyStimulus(4'b0000, 4'b1111, 4'b0000);
            settle();
            if (c == 5) begin
                checkOutput("single_end_ack", ack2, 4'b0000);
                checkOutput("single_end_busy", busy2, 1'b0);
                checkOutput("single_end_sram_reb", sram_reb2, 1'b1);
            end
            checkOutput("single_tail_rvalid", rvalid2, (c <= 6) ? 4'b0010 : 4'b0000);
            next_cycle();
        end
        checkOutput("rdata_lo", rdata2[63:0], 64'hA5A5_0123_4567_89AB);
        checkOutput("rdata_hi", rdata2[255:192], 64'hA5A5_0123_4567_89AB);

        // Contention: all four request, one-beat bursts, zero-bubble round robin
        do_reset();
        applyStimulus(4'b1111, 4'b0000, 4'b1111);
        settle();
        checkOutput("cont_idle_sram_reb", sram_reb2, 1'b1);
        next_cycle();
        for (int c = 1; c <= 5; c++) begin
            settle();
            checkOutput("cont_ack", ack2, 4'b0001 << ((c - 1) % 4));
            checkOutput("cont_busy", busy2, 1'b1);
            if (c >= 3) begin
                checkOutput("cont_rvalid", rvalid2, 4'b0001 << ((c - 3) % 4));
            end
            next_cycle();
        end

        // rid filter: requester 2 targets another bank
        do_reset();
        set_rid(2, 1);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(4'b0100, 4'b1011, 4'b0100);
            set_addr(2, 99);
            settle();
            checkOutput("rid_ack", ack2, 4'b0000);
            checkOutput("rid_sram_reb", sram_reb2, 1'b1);
            checkOutput("rid_rvalid", rvalid2, 4'b0000);
            next_cycle();
        end
        set_rid(2, 0);

        // Abort: owner 0 drops req after 2 beats, requester 3 takes over
        do_reset();
        applyStimulus(4'b1001, 4'b1111, 4'b0000);
        next_cycle();
        for (int c = 1; c <= 2; c++) begin
            applyStimulus(4'b1001, 4'b1110, 4'b0000);
            set_addr(0, 9 + c);
            settle();
            checkOutput("abort_ack0", ack2, 4'b0001);
            checkOutput("abort_addr0", sram_addr2, 9 + c);
            next_cycle();
        end
        applyStimulus(4'b1000, 4'b1111, 4'b0000);
        settle();
        checkOutput("abort_rel_ack", ack2, 4'b0001);
        checkOutput("abort_rel_sram_reb", sram_reb2, 1'b1);
        checkOutput("abort_rv1", rvalid2, 4'b0001);
        next_cycle();
        applyStimulus(4'b1000, 4'b0111, 4'b1000);
        set_addr(3, 20);
        settle();
        checkOutput("abort_ack3", ack2, 4'b1000);
        checkOutput("abort_addr3", sram_addr2, 20);
        checkOutput("abort_rv2", rvalid2, 4'b0001);
        next_cycle();
        applyStimulus(4'b0000, 4'b1111, 4'b0000);
        settle();
        checkOutput("abort_idle_ack", ack2, 4'b0000);
        checkOutput("abort_nobeat_rv", rvalid2, 4'b0000);
        next_cycle();
        settle();
        checkOutput("abort_rv3", rvalid2, 4'b1000);
        next_cycle();

        // Handoff with beats in flight, RD_LAT=3
        do_reset();
        applyStimulus(4'b0110, 4'b1111, 4'b0000);
        next_cycle();
        applyStimulus(4'b0110, 4'b1101, 4'b0000);
        set_addr(1, 1);
        settle();
        checkOutput("hand_ack1a", ack3, 4'b0010);
        next_cycle();
        applyStimulus(4'b0110, 4'b1101, 4'b0010);
        set_addr(1, 2);
        settle();
        checkOutput("hand_ack1b", ack3, 4'b0010);
        checkOutput("hand_addr1", sram_addr3, 2);
        next_cycle();
        applyStimulus(4'b0100, 4'b1011, 4'b0000);
        set_addr(2, 3);
        settle();
        checkOutput("hand_ack2a", ack3, 4'b0100);
        checkOutput("hand_addr2a", sram_addr3, 3);
        checkOutput("hand_rv_c3", rvalid3, 4'b0000);
        next_cycle();
        applyStimulus(4'b0100, 4'b1011, 4'b0100);
        set_addr(2, 4);
        settle();
        checkOutput("hand_addr2b", sram_addr3, 4);
        checkOutput("hand_rv_c4", rvalid3, 4'b0010);
        next_cycle();
        for (int c = 5; c <= 8; c++) begin
            applyStimulus(4'b0000, 4'b1111, 4'b0000);
            settle();
            if (c == 5) begin
                checkOutput("hand_end_ack", ack3, 4'b0000);
            end
            checkOutput("hand_rv_tail", rvalid3,
                        (c == 5) ? 4'b0010 : (c <= 7) ? 4'b0100 : 4'b0000);
            next_cycle();
        end

        // Reset mid-burst discards in-flight beats and rr_ptr
        do_reset();
        applyStimulus(4'b0100, 4'b1111, 4'b0000);
        next_cycle();
        applyStimulus(4'b1100, 4'b1011, 4'b0100);
        set_addr(2, 1);
        settle();
        checkOutput("rstm_ack2", ack2, 4'b0100);
        next_cycle();
        applyStimulus(4'b1000, 4'b0111, 4'b0000);
        set_addr(3, 30);
        settle();
        checkOutput("rstm_ack3", ack2, 4'b1000);
        checkOutput("rstm_addr30", sram_addr2, 30);
        next_cycle();
        rst = 1'b1;
        applyStimulus(4'b1000, 4'b0111, 4'b0000);
        set_addr(3, 31);
        settle();
        checkOutput("rstm_pre_ack", ack2, 4'b1000);
        checkOutput("rstm_pre_rv", rvalid2, 4'b0100);
        next_cycle();
        rst = 1'b0;
        applyStimulus(4'b1111, 4'b1111, 4'b0000);
        settle();
        checkOutput("rstm_ack", ack2, 4'b0000);
        checkOutput("rstm_busy", busy2, 1'b0);
        checkOutput("rstm_rvalid", rvalid2, 4'b0000);
        checkOutput("rstm_sram_reb", sram_reb2, 1'b1);
        checkOutput("rstm_sram_addr", sram_addr2, 0);
        next_cycle();
        settle();
        checkOutput("rstm_regrant", ack2, 4'b0001);
        checkOutput("rstm_rvalid2", rvalid2, 4'b0000);
        next_cycle();
        applyStimulus(4'b0000, 4'b1111, 4'b0000);
        settle();
        checkOutput("rstm_rvalid3", rvalid2, 4'b0000);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_bank_rd_arbiter.md
Name: sram_bank_rd_arbiter

Overview:
- Per-bank read-port arbiter. One instance sits in front of each SRAM bank's single read port.
- Shares the bank among NUM_REQ VPU source read ports using the req/ack/rid/addr/reb/rlast protocol, with round-robin fairness.
- The grant is held for a whole burst. Read data returns to the owning requester after a fixed SRAM latency.

Parameters:
- NUM_REQ, 4, number of requesting read ports (>=2).
- BANK_ID, 0, bank index this instance serves; compared against each requester's rid.
- BANK_CNT_LG2, 2, width of rid.
- DEPTH_LG2, 10, SRAM word-address width.
- DATA_WIDTH, 256, SRAM data width.
- RD_LAT, 2, cycles from the SRAM read-issue edge to rdata valid (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_i  in  NUM_REQ  per-requester ownership request
- rid_i  in  NUM_REQ*BANK_CNT_LG2  per-requester bank id, packed, requester k at [k*BANK_CNT_LG2 +: BANK_CNT_LG2]
- addr_i  in  NUM_REQ*DEPTH_LG2  per-requester word address, packed
- reb_i  in  NUM_REQ  per-requester read enable, active-low
- rlast_i  in  NUM_REQ  final beat of burst, qualified by reb_i=0
- ack_o  out  NUM_REQ  one-hot ownership grant
- rdata_o  out  DATA_WIDTH  read data, broadcast to all requesters
- rvalid_o  out  NUM_REQ  one-hot read-data valid for the owner of the returning beat
- sram_reb_o  out  1  bank read enable, active-low
- sram_addr_o  out  DEPTH_LG2  bank address
- sram_rdata_i  in  DATA_WIDTH  bank read data
- busy_o  out  1  bank currently owned

Behaviour:
- Eligibility: requester k is eligible when req_i[k]=1 and rid_i[k]==BANK_ID.
- FSM states: IDLE, BUSY. Registers:
  - owner (clog2(NUM_REQ) bits)
  - rr_ptr, the highest-priority index
  - rd pipeline of RD_LAT stages, each {valid, owner}
- IDLE:
  - If any requester is eligible, pick the first eligible index searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - owner <= winner; go to BUSY.
  - Otherwise stay in IDLE.
  - Request-to-ack latency is 1 cycle.
- BUSY:
  - ack_o = onehot(owner), registered.
  - sram_reb_o = reb_i[owner]; sram_addr_o = addr_i[owner] (combinational mux).
  - A beat issues when reb_i[owner]=0; it pushes {1, owner} into rd stage 0.
- Release: occurs on the cycle when reb_i[owner]=0 and rlast_i[owner]=1, or when the owner is no longer eligible (abort; no beat issues that cycle unless reb_i=0).
  - On release, rr_ptr <= owner+1 modulo NUM_REQ.
  - The same cycle, arbitrate among eligible requesters excluding the current owner, starting at owner+1.
  - If a winner exists: owner <= winner, stay in BUSY. This is a zero-bubble handoff; ack moves directly between requesters.
  - Otherwise go to IDLE.
  - Next grant, from a single requester, is therefore at least 1 cycle after its own release.
- Outside BUSY: sram_reb_o=1, sram_addr_o=0, ack_o=0.
  - Inputs from non-owners never reach the SRAM.
  - reb_i=0 by a non-owner is ignored and produces no rvalid.
- Read return:
  - rd stages shift every cycle.
  - rvalid_o = onehot(stage[RD_LAT-1].owner) when stage[RD_LAT-1].valid, else 0.
  - rdata_o = sram_rdata_i, passed through.
  - In-flight beats complete to their original owner even after a handoff. Returns stay in issue order.
- Timing: one beat per cycle sustained. A burst of N beats releases on the beat-N cycle.
- Simultaneous events:
  - New requests arriving during BUSY wait.
  - An eligibility drop on the same cycle as rlast is treated as a normal release; the beat is issued.
- Reset, synchronous:
  - FSM -> IDLE; owner=0; rr_ptr=0; all rd stages invalid.
  - ack_o=0, rvalid_o=0, busy_o=0, sram_reb_o=1, sram_addr_o=0.
  - Reset mid-burst discards in-flight beats; no rvalid is produced after reset.
- busy_o = (state==BUSY).

Test Plan:
- Single requester, RD_LAT=2:
  - req_i[1]=1, rid=BANK_ID at cycle 0 -> ack_o=0010 at cycle 1.
  - Issue addrs 5,6,7,8 with reb=0 on cycles 1-4 and rlast on cycle 4 -> sram_addr_o=5..8 on cycles 1-4.
  - rvalid_o=0010 on cycles 3-6.
  - Cycle 5: ack_o=0, busy_o=0.
- Contention:
  - req_i=1111, each doing 1-beat bursts from reset -> ack order 0,1,2,3,0.
  - Zero idle cycles between grants.
- rid filter:
  - req_i[2]=1 with rid!=BANK_ID for 10 cycles -> ack_o stays 0, sram_reb_o stays 1.
- Abort:
  - Owner 0 drops req after 2 of 4 beats -> release that cycle; requester 3 (waiting) acked the next cycle.
  - Both issued beats still return rvalid_o=0001.
- Handoff with in-flight data, RD_LAT=3:
  - Owner 1 finishes its burst; requester 2 is granted immediately.
  - Returning beats show rvalid_o=0010 then 0100 with no gap or reorder.
- Reset mid-burst:
  - Assert rst for 1 cycle after 2 of 4 beats issued -> all outputs at reset values next cycle.
  - No rvalid for the 2 in-flight beats.
  - A fresh request is granted in 1 cycle, starting from rr_ptr=0.
